// File: rtl/audioport_pkg.sv
// Shared audio-port constants and types for the mclk-domain output stage.
package audioport_pkg;

    localparam int MCLK_DIV_48000 = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        STOPPING = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing: mclk divider, slot counter, registered sck and frame strobes.
// Strobes look one cycle ahead so downstream flops line up with the counters.
module i2s_clkgen
    import audioport_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int MCLK_DIV   = MCLK_DIV_48000,
    parameter int SLOT_W     = $clog2(2 * DATA_WIDTH)
) (
    input  logic              mclk,
    input  logic              mrst_n,
    input  logic              run_cur_i,
    input  logic              run_nxt_i,
    output logic              sck_o,
    output logic              frame_start_nxt_o,
    output logic              slot_adv_nxt_o,
    output logic              last_cycle_o,
    output logic [SLOT_W-1:0] slot_nxt_o
);
    localparam int DIV_W = $clog2(MCLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(2 * DATA_WIDTH - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              sck_q, sck_d;
    logic              div_wrap;

    assign div_wrap = run_cur_i && (div_q == DIV_MAX);

    // Counters sit at zero whenever the next cycle is idle, so a restart always begins a frame.
    always_comb begin
        div_d  = div_q;
        slot_d = slot_q;
        if (!run_nxt_i) begin
            div_d  = '0;
            slot_d = '0;
        end else if (run_cur_i) begin
            if (div_wrap) begin
                div_d  = '0;
                slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        sck_d = run_nxt_i && (div_d >= DIV_HALF);
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            div_q  <= '0;
            slot_q <= '0;
            sck_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
            sck_q  <= sck_d;
        end
    end

    assign sck_o             = sck_q;
    assign frame_start_nxt_o = run_nxt_i && (div_d == '0) && (slot_d == '0);
    assign slot_adv_nxt_o    = div_wrap;
    assign last_cycle_o      = div_wrap && (slot_q == SLOT_MAX);
    assign slot_nxt_o        = slot_d;

endmodule

// File: rtl/i2s_unit.sv
// Stereo I2S serialiser: one-deep sample buffer, frame shift register, play/stop FSM.
// Latency: tick and first sck low one cycle after play; no backpressure, underrun plays silence.
module i2s_unit
    import audioport_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int MCLK_DIV   = MCLK_DIV_48000
) (
    input  logic                  mclk,
    input  logic                  mrst_n,
    input  logic                  play_in,
    input  logic                  req_in,
    input  logic [DATA_WIDTH-1:0] audio0_in,
    input  logic [DATA_WIDTH-1:0] audio1_in,
    output logic                  tick_out,
    output logic                  sck_out,
    output logic                  ws_out,
    output logic                  sdo_out
);
    localparam int FW     = 2 * DATA_WIDTH;
    localparam int SLOT_W = $clog2(FW);
    localparam logic [SLOT_W-1:0] WS_FIRST = SLOT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0] WS_LAST  = SLOT_W'(FW - 2);

    i2s_state_t        state_q, state_d;
    logic [FW-1:0]     data_buf_q, data_buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [FW-1:0]     shreg_q, shreg_d;
    logic              tick_q, ws_q, ws_d;
    logic              run_cur, run_nxt, to_idle;
    logic              fs_nxt, slot_adv, last_cycle;
    logic [SLOT_W-1:0] slot_nxt;

    i2s_clkgen #(
        .DATA_WIDTH (DATA_WIDTH),
        .MCLK_DIV   (MCLK_DIV),
        .SLOT_W     (SLOT_W)
    ) u_clkgen (
        .mclk              (mclk),
        .mrst_n            (mrst_n),
        .run_cur_i         (run_cur),
        .run_nxt_i         (run_nxt),
        .sck_o             (sck_out),
        .frame_start_nxt_o (fs_nxt),
        .slot_adv_nxt_o    (slot_adv),
        .last_cycle_o      (last_cycle),
        .slot_nxt_o        (slot_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (play_in)    state_d = PLAY;
            PLAY:     if (!play_in)   state_d = STOPPING;
            STOPPING: if (last_cycle) state_d = play_in ? PLAY : IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    assign run_cur = (state_q != IDLE);
    assign run_nxt = (state_d != IDLE);
    assign to_idle = run_cur && !run_nxt;

    // The frame-start load reads the buffer before a same-edge req_in overwrites it.
    always_comb begin
        data_buf_d = data_buf_q;
        buf_vld_d  = buf_vld_q;
        if (to_idle) begin
            data_buf_d = '0;
            buf_vld_d  = 1'b0;
        end else begin
            if (fs_nxt) buf_vld_d = 1'b0;
            if (req_in) begin
                data_buf_d = {audio0_in, audio1_in};
                buf_vld_d  = 1'b1;
            end
        end

        shreg_d = shreg_q;
        if (!run_nxt)      shreg_d = '0;
        else if (fs_nxt)   shreg_d = buf_vld_q ? data_buf_q : '0;
        else if (slot_adv) shreg_d = {shreg_q[FW-2:0], 1'b0};

        ws_d = run_nxt && (slot_nxt >= WS_FIRST) && (slot_nxt <= WS_LAST);
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q    <= IDLE;
            data_buf_q <= '0;
            buf_vld_q  <= 1'b0;
            shreg_q    <= '0;
            tick_q     <= 1'b0;
            ws_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_buf_q <= data_buf_d;
            buf_vld_q  <= buf_vld_d;
            shreg_q    <= shreg_d;
            tick_q     <= fs_nxt;
            ws_q       <= ws_d;
        end
    end

    assign tick_out = tick_q;
    assign ws_out   = ws_q;
    assign sdo_out  = shreg_q[FW-1];

endmodule

// File: tb/tb_i2s_unit.sv
// Randomised bench for i2s_unit against a frame-position reference model.
module tb_i2s_unit;
    localparam int DW    = 24;
    localparam int DIV   = 8;
    localparam int FW    = 2 * DW;
    localparam int FRAME = FW * DIV;

    logic          mclk = 1'b0;
    logic          mrst_n = 1'b0;
    logic          play_in = 1'b0;
    logic          req_in = 1'b0;
    logic [DW-1:0] audio0_in = '0;
    logic [DW-1:0] audio1_in = '0;
    logic          tick_out, sck_out, ws_out, sdo_out;

    int checks = 0;
    int errors = 0;

    // Reference model: running flag, position within the 384-cycle frame, latched frame word.
    bit            m_run, m_stop, m_tick, m_vld;
    int            m_pos;
    logic [FW-1:0] m_frame, m_buf;

    bit auto_req = 1'b0;
    int req_delay = -1;

    i2s_unit #(.DATA_WIDTH(DW), .MCLK_DIV(DIV)) dut (
        .mclk      (mclk),
        .mrst_n    (mrst_n),
        .play_in   (play_in),
        .req_in    (req_in),
        .audio0_in (audio0_in),
        .audio1_in (audio1_in),
        .tick_out  (tick_out),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .sdo_out   (sdo_out)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_stop = 0; m_tick = 0; m_vld = 0;
        m_pos = 0; m_frame = '0; m_buf = '0;
    endfunction

    function automatic void model_edge();
        bit go_idle;
        go_idle = 0;
        if (!mrst_n) begin
            model_reset();
            return;
        end
        m_tick = 0;
        if (!m_run) begin
            if (play_in) begin
                m_run = 1; m_stop = 0; m_pos = 0; m_tick = 1;
            end
        end else if (m_pos == FRAME - 1 && m_stop && !play_in) begin
            go_idle = 1; m_run = 0; m_stop = 0; m_pos = 0;
        end else begin
            if (m_pos == FRAME - 1 && m_stop) m_stop = 0;
            else if (!play_in)                m_stop = 1;
            m_pos  = (m_pos + 1) % FRAME;
            m_tick = (m_pos == 0);
        end
        if (m_tick) begin
            m_frame = m_vld ? m_buf : '0;
            m_vld   = 0;
        end
        if (go_idle) begin
            m_buf = '0; m_vld = 0; m_frame = '0;
        end else if (req_in) begin
            m_buf = {audio0_in, audio1_in};
            m_vld = 1;
        end
    endfunction

    function automatic logic [3:0] exp_outs();
        int slot;
        if (!m_run) return 4'b0000;
        slot = m_pos / DIV;
        return {m_tick, (m_pos % DIV) >= DIV / 2, (slot >= DW - 1 && slot <= FW - 2), m_frame[FW-1-slot]};
    endfunction

    task automatic step();
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        check_eq("outs{tick,sck,ws,sdo}", 64'({tick_out, sck_out, ws_out, sdo_out}), 64'(exp_outs()));
        req_in = 1'b0;
        if (auto_req) begin
            if (tick_out) req_delay = $urandom_range(0, 40);
            if (req_delay == 0) begin
                req_in    = 1'b1;
                audio0_in = DW'($urandom);
                audio1_in = DW'($urandom);
            end
            if (req_delay >= 0) req_delay--;
        end
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_out && n < 2000);
        check_eq(tag, 64'(tick_out), 64'(1));
    endtask

    // Called in a tick cycle; collects sdo/ws at each sck rise over the rest of the frame.
    task automatic cap_frame(output logic [FW-1:0] d, output logic [FW-1:0] w, output int hi);
        logic prev;
        int   nb;
        d = '0; w = '0; hi = 0; nb = 0;
        prev = sck_out;
        for (int i = 1; i < FRAME; i++) begin
            step();
            if (sck_out && !prev) begin
                d = {d[FW-2:0], sdo_out};
                w = {w[FW-2:0], ws_out};
                nb++;
            end
            hi += int'(sck_out);
            prev = sck_out;
        end
        check_eq("bit_count", 64'(nb), 64'(FW));
    endtask

    initial begin
        logic [FW-1:0] d, w;
        int hi, ticks, act, n;

        model_reset();
        repeat (3) @(negedge mclk);
        check_eq("reset_outs", 64'({tick_out, sck_out, ws_out, sdo_out}), 64'(0));
        mrst_n = 1'b1;
        repeat (5) step();

        // Known pattern loaded while idle, then start.
        audio0_in = 24'h800001; audio1_in = 24'h7FFFFE; req_in = 1'b1;
        step();
        play_in = 1'b1;
        step();
        check_eq("first_tick", 64'(tick_out), 64'(1));
        cap_frame(d, w, hi);
        check_eq("frame_data", 64'(d), 64'h8000017FFFFE);
        check_eq("ws_pattern", 64'(w), 64'h000001FFFFFE);
        check_eq("sck_duty", 64'(hi), 64'(FRAME / 2));
        step();
        check_eq("tick_gap", 64'(tick_out), 64'(1));

        cap_frame(d, w, hi);
        check_eq("underrun_data", 64'(d), 64'(0));
        step();
        check_eq("tick_gap_underrun", 64'(tick_out), 64'(1));

        // Collision: A buffered mid-frame, B arrives in the frame-start cycle.
        repeat (50) step();
        audio0_in = 24'h123456; audio1_in = 24'hABCDEF; req_in = 1'b1;
        step();
        wait_tick("coll_tick");
        audio0_in = 24'h0F0F0F; audio1_in = 24'hC3C3C3; req_in = 1'b1;
        cap_frame(d, w, hi);
        check_eq("coll_frame_a", 64'(d), 64'h123456ABCDEF);
        step();
        check_eq("coll_tick_b", 64'(tick_out), 64'(1));
        cap_frame(d, w, hi);
        check_eq("coll_frame_b", 64'(d), 64'h0F0F0FC3C3C3);
        step();
        check_eq("tick_gap_b", 64'(tick_out), 64'(1));

        // Stop at slot 10: frame runs to completion, then silence with no ticks.
        repeat (80) step();
        play_in = 1'b0;
        hi = 0; ticks = 0;
        repeat (FRAME - 1 - 80) begin
            step();
            hi += int'(sck_out);
            ticks += int'(tick_out);
        end
        check_eq("stop_tail_sck", 64'(hi), 64'(152));
        check_eq("stop_tail_ticks", 64'(ticks), 64'(0));
        ticks = 0; act = 0;
        repeat (400) begin
            step();
            ticks += int'(tick_out);
            act += int'(sck_out) + int'(ws_out) + int'(sdo_out);
        end
        check_eq("idle_ticks", 64'(ticks), 64'(0));
        check_eq("idle_activity", 64'(act), 64'(0));

        // Restart, drop at slot 5, re-raise at slot 30: next frame with no gap.
        play_in = 1'b1;
        step();
        check_eq("restart_tick", 64'(tick_out), 64'(1));
        repeat (39) step();
        play_in = 1'b0;
        step();
        audio0_in = 24'hFFFFFF; audio1_in = 24'hFFFFFF; req_in = 1'b1;
        step();
        repeat (199) step();
        play_in = 1'b1;
        n = 240;
        do begin
            step();
            n++;
        end while (!tick_out && n < 2 * FRAME);
        check_eq("no_gap_spacing", 64'(n), 64'(FRAME));

        // Asynchronous reset mid-frame with sck high and sdo high.
        repeat (164) step();
        check_eq("pre_reset_sdo", 64'(sdo_out), 64'(1));
        #2 mrst_n = 1'b0;
        #1 check_eq("async_reset", 64'({tick_out, sck_out, ws_out, sdo_out}), 64'(0));
        model_reset();
        repeat (2) step();
        mrst_n = 1'b1;
        step();
        check_eq("post_reset_tick", 64'(tick_out), 64'(1));

        // Random traffic and play toggling against the model.
        auto_req = 1'b1;
        repeat (9000) begin
            step();
            if ($urandom_range(0, 599) == 0) play_in = ~play_in;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
